// File: rtl/ft_pkg.sv
// Shared types for the fault-tolerance recovery path: FSM states,
// register address width and counter widths.
package ft_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int RETRY_W    = 8;
  localparam int QUIET_W    = 16;
  localparam int REC_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_READ,
    ST_WRITE,
    ST_RESUME,
    ST_FATAL
  } state_t;

endpackage

// File: rtl/sgpr_recovery_ctrl.sv
// Lockstep recovery controller: on core divergence, halts both cores,
// copies shadow GPRs x1..xN-1 back into the cores, then resumes.
// Ports: clk/rst_n (sync, active-low); mismatch_i from comparator;
// halt_o/halt_ack_i core stall handshake; sgpr_raddr_o/sgpr_rdata_i
// shadow read; core_we_o/waddr/wdata/core_ready_i restore write;
// busy_o, done_o (pulse), fatal_o (sticky), rec_count_o (saturating).
module sgpr_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int MAX_RETRY    = 3,
  parameter int QUIET_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mismatch_i,
  output logic                  halt_o,
  input  logic                  halt_ack_i,
  output logic [REG_ADDR_W-1:0] sgpr_raddr_o,
  input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
  output logic                  core_we_o,
  output logic [REG_ADDR_W-1:0] core_waddr_o,
  output logic [DATA_WIDTH-1:0] core_wdata_o,
  input  logic                  core_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fatal_o,
  output logic [REC_W-1:0]      rec_count_o
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX =
    REG_ADDR_W'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRY);
  localparam logic [QUIET_W-1:0] QUIET_LAST =
    QUIET_W'(QUIET_CYCLES - 1);

  state_t                state;
  logic [REG_ADDR_W-1:0] idx;
  logic [RETRY_W-1:0]    retry_cnt;
  logic [QUIET_W-1:0]    quiet_cnt;

  // core_wdata_o doubles as the captured-data register: it is loaded
  // in READ and held unchanged for the whole WRITE beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      retry_cnt    <= '0;
      quiet_cnt    <= '0;
      halt_o       <= 1'b0;
      sgpr_raddr_o <= '0;
      core_we_o    <= 1'b0;
      core_waddr_o <= '0;
      core_wdata_o <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      fatal_o      <= 1'b0;
      rec_count_o  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mismatch_i) begin
            quiet_cnt <= '0;
            halt_o    <= 1'b1;
            busy_o    <= 1'b1;
            if (retry_cnt < RETRY_MAX) begin
              state     <= ST_HALT;
              retry_cnt <= retry_cnt + 1'b1;
              if (rec_count_o != '1)
                rec_count_o <= rec_count_o + 1'b1;
            end else begin
              state   <= ST_FATAL;
              fatal_o <= 1'b1;
            end
          end else if (quiet_cnt == QUIET_LAST) begin
            quiet_cnt <= '0;
            retry_cnt <= '0;
          end else begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end
        end
        ST_HALT: begin
          if (halt_ack_i) begin
            idx          <= REG_ADDR_W'(1);
            sgpr_raddr_o <= REG_ADDR_W'(1);
            state        <= ST_READ;
          end
        end
        ST_READ: begin
          core_we_o    <= 1'b1;
          core_waddr_o <= idx;
          core_wdata_o <= sgpr_rdata_i;
          sgpr_raddr_o <= '0;
          state        <= ST_WRITE;
        end
        ST_WRITE: begin
          if (core_ready_i) begin
            core_we_o    <= 1'b0;
            core_waddr_o <= '0;
            core_wdata_o <= '0;
            if (idx == LAST_IDX) begin
              done_o <= 1'b1;
              state  <= ST_RESUME;
            end else begin
              idx          <= idx + 1'b1;
              sgpr_raddr_o <= idx + 1'b1;
              state        <= ST_READ;
            end
          end
        end
        ST_RESUME: begin
          done_o <= 1'b0;
          halt_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_FATAL: begin
          fatal_o   <= 1'b1;
          halt_o    <= 1'b1;
          busy_o    <= 1'b1;
          core_we_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sgpr_recovery_ctrl.sv
// Directed bench for sgpr_recovery_ctrl: basic restore, backpressure,
// retry exhaustion, quiet window, reset mid-restore, ignored mismatch.
module tb_sgpr_recovery_ctrl;
  import ft_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mismatch;
  logic        halt;
  logic        halt_ack;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        ready;
  logic        busy;
  logic        done;
  logic        fatal;
  logic [7:0]  rec;

  logic [31:0] sgpr [32];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign rdata = sgpr[raddr];

  sgpr_recovery_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mismatch_i   (mismatch),
    .halt_o       (halt),
    .halt_ack_i   (halt_ack),
    .sgpr_raddr_o (raddr),
    .sgpr_rdata_i (rdata),
    .core_we_o    (we),
    .core_waddr_o (waddr),
    .core_wdata_o (wdata),
    .core_ready_i (ready),
    .busy_o       (busy),
    .done_o       (done),
    .fatal_o      (fatal),
    .rec_count_o  (rec)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One recovery: pulse mismatch, ack halt 3 cycles later, then act
  // as the cores. bp_idx/bp_len stall the write of one register,
  // mm_idx pulses mismatch mid-restore, rst_idx asserts reset there.
  task automatic run_restore(input int bp_idx, input int bp_len,
                             input int mm_idx, input int rst_idx,
                             output int nwr, output int ndone,
                             output int lat, output int bad);
    int exp_i, stall, first_rd, done_cyc;
    logic [4:0]  hold_a;
    logic [31:0] hold_d;
    nwr = 0; ndone = 0; lat = -1; bad = 0;
    exp_i = 1; stall = 0; first_rd = -1; done_cyc = -1;
    hold_a = '0; hold_d = '0;
    mismatch = 1'b1;
    @(negedge clk);
    mismatch = 1'b0;
    chk("halt_rise", 32'(halt), 32'd1);
    repeat (3) @(negedge clk);
    chk("halt_wait_raddr", 32'(raddr), 32'd0);
    halt_ack = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      mismatch = 1'b0;
      if (raddr != 0 && first_rd < 0) first_rd = c;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
        halt_ack = 1'b0;
      end
      if (we) begin
        if (rst_idx > 0 && int'(waddr) == rst_idx) begin
          rst_n = 1'b0;
          break;
        end
        if (mm_idx > 0 && int'(waddr) == mm_idx) mismatch = 1'b1;
        if (int'(waddr) == bp_idx && stall < bp_len) begin
          if (stall > 0 && (waddr != hold_a || wdata != hold_d))
            bad++;
          hold_a = waddr;
          hold_d = wdata;
          stall++;
          ready = 1'b0;
        end else begin
          ready = 1'b1;
          if (int'(waddr) != exp_i ||
              wdata != 32'h1000 + 32'(exp_i))
            bad++;
          exp_i++;
          nwr++;
        end
      end else begin
        ready = 1'b1;
      end
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
    if (done_cyc >= 0 && first_rd >= 0) lat = done_cyc - first_rd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mismatch = 1'b0;
    halt_ack = 1'b0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int nwr, nd, lat, bad, we_seen;

  initial begin
    for (int i = 0; i < 32; i++) sgpr[i] = 32'h1000 + 32'(i);
    rst_n = 1'b0;
    mismatch = 1'b0;
    halt_ack = 1'b0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_halt",  32'(halt),  32'd0);
    chk("rst_we",    32'(we),    32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata,      32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_fatal", 32'(fatal), 32'd0);
    chk("rst_rec",   32'(rec),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic restore
    run_restore(0, 0, 0, 0, nwr, nd, lat, bad);
    chk("basic_nwr",  32'(nwr), 32'd31);
    chk("basic_seq",  32'(bad), 32'd0);
    chk("basic_done", 32'(nd),  32'd1);
    chk("basic_lat",  32'(lat), 32'd62);
    chk("basic_rec",  32'(rec), 32'd1);
    chk("basic_halt_off", 32'(halt), 32'd0);
    chk("basic_busy_off", 32'(busy), 32'd0);

    // backpressure on x7 for 5 cycles
    run_restore(7, 5, 0, 0, nwr, nd, lat, bad);
    chk("bp_nwr",  32'(nwr), 32'd31);
    chk("bp_seq",  32'(bad), 32'd0);
    chk("bp_done", 32'(nd),  32'd1);
    chk("bp_lat",  32'(lat), 32'd67);
    chk("bp_rec",  32'(rec), 32'd2);

    // mismatch mid-restore is ignored
    run_restore(0, 0, 10, 0, nwr, nd, lat, bad);
    chk("mm_nwr",  32'(nwr), 32'd31);
    chk("mm_seq",  32'(bad), 32'd0);
    chk("mm_done", 32'(nd),  32'd1);
    chk("mm_rec",  32'(rec), 32'd3);
    repeat (3) @(negedge clk);
    chk("mm_idle_halt", 32'(halt), 32'd0);
    chk("mm_idle_busy", 32'(busy), 32'd0);

    // retry exhaustion
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_restore(0, 0, 0, 0, nwr, nd, lat, bad);
      chk("rx_nwr", 32'(nwr), 32'd31);
      chk("rx_done", 32'(nd), 32'd1);
    end
    mismatch = 1'b1;
    @(negedge clk);
    mismatch = 1'b0;
    chk("rx_fatal", 32'(fatal), 32'd1);
    chk("rx_halt",  32'(halt),  32'd1);
    chk("rx_busy",  32'(busy),  32'd1);
    chk("rx_rec",   32'(rec),   32'd3);
    halt_ack = 1'b1;
    we_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (we) we_seen++;
    end
    halt_ack = 1'b0;
    chk("rx_fatal_sticky", 32'(fatal), 32'd1);
    chk("rx_halt_sticky",  32'(halt),  32'd1);
    chk("rx_no_we",        32'(we_seen), 32'd0);

    // quiet window clears retry count
    do_reset();
    chk("qw_fatal_cleared", 32'(fatal), 32'd0);
    for (int k = 0; k < 3; k++)
      run_restore(0, 0, 0, 0, nwr, nd, lat, bad);
    repeat (1030) @(negedge clk);
    run_restore(0, 0, 0, 0, nwr, nd, lat, bad);
    chk("qw_nwr",   32'(nwr),   32'd31);
    chk("qw_done",  32'(nd),    32'd1);
    chk("qw_fatal", 32'(fatal), 32'd0);
    chk("qw_rec",   32'(rec),   32'd4);

    // reset mid-restore at x15
    run_restore(0, 0, 0, 15, nwr, nd, lat, bad);
    chk("mr_reached", 32'(rst_n), 32'd0);
    @(negedge clk);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_we",   32'(we),   32'd0);
    chk("mr_rec",  32'(rec),  32'd0);
    chk("mr_halt", 32'(halt), 32'd0);
    rst_n = 1'b1;
    halt_ack = 1'b0;
    we_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (we) we_seen++;
    end
    chk("mr_no_we", 32'(we_seen), 32'd0);
    chk("mr_idle",  32'(busy),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
